rd_burst_gen: RTL and testbench

RD_BURST_GEN -- requirements
Module: rd_burst_gen

---
 rtl/rd_burst_gen.sv | 121 ++++++++++++
 tb/tb_rd_burst_gen.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_burst_gen.sv
// Splits a read command into AXI AR bursts and pushes one descriptor per burst into the read-info FIFO.
// Define RD_BURST_4K_SPLIT_EN to keep every burst inside a 4 KB page.
module rd_burst_gen #(
  parameter int NUM_PU        = 1,
  parameter int D_TYPE_W      = 2,
  parameter int RD_SIZE_W     = 20,
  parameter int AXI_ADDR_W    = 32,
  parameter int MAX_BURST_LEN = 16,
  parameter int DATA_BYTES    = 8,
  localparam int PU_ID_W      = $clog2(NUM_PU) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [AXI_ADDR_W-1:0] cmd_addr,
  input  logic [RD_SIZE_W-1:0]  cmd_size,
  input  logic [PU_ID_W-1:0]    cmd_pu_id,
  input  logic [D_TYPE_W-1:0]   cmd_d_type,
  output logic                  ar_valid,
  input  logic                  ar_ready,
  output logic [AXI_ADDR_W-1:0] ar_addr,
  output logic [7:0]            ar_len,
  output logic                  rd_req,
  output logic [RD_SIZE_W-1:0]  rd_req_size,
  output logic [PU_ID_W-1:0]    rd_req_pu_id,
  output logic [D_TYPE_W-1:0]   rd_req_d_type,
  input  logic                  read_info_full,
  output logic                  busy
);
  localparam int BEATS_W = $clog2(MAX_BURST_LEN) + 1;
  localparam int CW      = (RD_SIZE_W > 13) ? RD_SIZE_W : 13;
  localparam int BSH     = $clog2(DATA_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ISSUE} state_t;

  state_t                  state_q, state_d;
  logic [AXI_ADDR_W-1:0]   addr_q, addr_d;
  logic [RD_SIZE_W-1:0]    rem_q, rem_d;
  logic [PU_ID_W-1:0]      pu_q, pu_d;
  logic [D_TYPE_W-1:0]     dt_q, dt_d;
  logic [BEATS_W-1:0]      beats_q, beats_d;
  logic [BEATS_W-1:0]      calc_beats;
  logic [CW-1:0]           cand;
  logic                    push;

  // Burst size candidate; the page limit is always >= 1 because addr is beat-aligned.
  always_comb begin
    cand = (CW'(rem_q) < CW'(MAX_BURST_LEN)) ? CW'(rem_q) : CW'(MAX_BURST_LEN);
`ifdef RD_BURST_4K_SPLIT_EN
    if (((CW'(4096) - CW'(addr_q[11:0])) >> BSH) < cand)
      cand = (CW'(4096) - CW'(addr_q[11:0])) >> BSH;
`endif
    calc_beats = BEATS_W'(cand);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    pu_d    = pu_q;
    dt_d    = dt_q;
    beats_d = beats_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          rem_d  = cmd_size;
          pu_d   = cmd_pu_id;
          dt_d   = cmd_d_type;
          if (cmd_size != '0) state_d = S_CALC;
        end
      end
      S_CALC: begin
        beats_d = calc_beats;
        if (!read_info_full) begin
          push    = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ar_ready) begin
          addr_d  = addr_q + (AXI_ADDR_W'(beats_q) << BSH);
          rem_d   = rem_q - RD_SIZE_W'(beats_q);
          state_d = (rem_q == RD_SIZE_W'(beats_q)) ? S_IDLE : S_CALC;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      pu_q    <= '0;
      dt_q    <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      pu_q    <= pu_d;
      dt_q    <= dt_d;
      beats_q <= beats_d;
    end
  end

  // Outputs decode from state, so async reset clears them without a clock edge.
  assign cmd_ready     = (state_q == S_IDLE) && !reset;
  assign busy          = (state_q != S_IDLE);
  assign ar_valid      = (state_q == S_ISSUE);
  assign ar_addr       = ar_valid ? addr_q : '0;
  assign ar_len        = ar_valid ? 8'(beats_q - 1'b1) : 8'd0;
  assign rd_req        = push;
  assign rd_req_size   = push ? RD_SIZE_W'(calc_beats - 1'b1) : '0;
  assign rd_req_pu_id  = push ? pu_q : '0;
  assign rd_req_d_type = push ? dt_q : '0;
endmodule

// File: tb/tb_rd_burst_gen.sv
// Bench for rd_burst_gen: command table plus model-filled scoreboard queues, and hand sequences
// for backpressure, stalled AR, zero-size commands and mid-burst reset.
module tb_rd_burst_gen;
  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [19:0] cmd_size;
  logic        cmd_pu_id;
  logic [1:0]  cmd_d_type;
  logic        ar_valid, ar_ready;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic        rd_req;
  logic [19:0] rd_req_size;
  logic        rd_req_pu_id;
  logic [1:0]  rd_req_d_type;
  logic        read_info_full;
  logic        busy;

  rd_burst_gen dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_size(cmd_size),
    .cmd_pu_id(cmd_pu_id), .cmd_d_type(cmd_d_type),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
    .rd_req(rd_req), .rd_req_size(rd_req_size), .rd_req_pu_id(rd_req_pu_id),
    .rd_req_d_type(rd_req_d_type), .read_info_full(read_info_full), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [7:0] len; } ar_t;
  typedef struct { logic [19:0] sz; logic pu; logic [1:0] dt; } rq_t;
  typedef struct {
    logic [31:0] addr; int size; logic pu; logic [1:0] dt;
    int exp_bursts; logic [31:0] exp_addr0; int exp_len0;
  } vec_t;

  ar_t qa[$];
  rq_t qr[$];
  int  total = 0, passed = 0;
  int  n_ar = 0, n_rq = 0;
  int  ar_mode = 0;  // 0 random, 1 held low, 2 held high
  logic        pend = 1'b0;
  logic [31:0] pend_a;
  logic [7:0]  pend_l;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
  endtask

  // Reference burst split, independent of the DUT's state machine
  task automatic model_push(input logic [31:0] a0, input int sz, input logic p, input logic [1:0] d);
    logic [31:0] a;
    int r, b;
    a = a0; r = sz;
    while (r > 0) begin
      b = (r < 16) ? r : 16;
`ifdef RD_BURST_4K_SPLIT_EN
      if ((4096 - int'(a[11:0])) / 8 < b) b = (4096 - int'(a[11:0])) / 8;
`endif
      qa.push_back('{a, 8'(b - 1)});
      qr.push_back('{20'(b - 1), p, d});
      a = a + 32'(b * 8);
      r = r - b;
    end
  endtask

  initial begin
    ar_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ar_mode)
        0: ar_ready = 1'($urandom_range(0, 1));
        1: ar_ready = 1'b0;
        default: ar_ready = 1'b1;
      endcase
    end
  end

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      if (rd_req) begin
        n_rq++;
        if (qr.size() == 0) chk("rd_req_unexpected", 1, 0);
        else begin
          rq_t e;
          e = qr.pop_front();
          chk("rd_req_size", rd_req_size, e.sz);
          chk("rd_req_pu_id", rd_req_pu_id, e.pu);
          chk("rd_req_d_type", rd_req_d_type, e.dt);
        end
      end
      if (pend) begin
        chk("ar_valid_hold", ar_valid, 1);
        chk("ar_addr_hold", ar_addr, pend_a);
        chk("ar_len_hold", ar_len, pend_l);
      end
      pend = ar_valid && !ar_ready;
      pend_a = ar_addr;
      pend_l = ar_len;
      if (ar_valid && ar_ready) begin
        n_ar++;
        chk("rd_req_before_ar", n_rq >= n_ar, 1);
        if (qa.size() == 0) chk("ar_unexpected", 1, 0);
        else begin
          ar_t e;
          e = qa.pop_front();
          chk("ar_addr", ar_addr, e.a);
          chk("ar_len", ar_len, e.len);
        end
      end
    end else pend = 1'b0;
  end

  task automatic send_cmd(input logic [31:0] a, input int sz, input logic p, input logic [1:0] d,
                          input bit lat);
    int k;
    @(posedge clk); #1;
    cmd_addr = a; cmd_size = 20'(sz); cmd_pu_id = p; cmd_d_type = d; cmd_valid = 1'b1;
    model_push(a, sz, p, d);
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 100) begin @(negedge clk); k++; end
    chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (lat) begin
      @(negedge clk);
      chk("calc_busy", busy, 1);
      chk("calc_no_ar", ar_valid, 0);
      @(negedge clk);
      chk("ar_latency", ar_valid, 1);
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (busy && k < 3000) begin @(negedge clk); k++; end
    chk("cmd_done", busy, 0);
    chk("ar_queue_drained", qa.size(), 0);
    chk("rq_queue_drained", qr.size(), 0);
  endtask

  initial begin
    vec_t vt[$];
    int   ar0, rq0;
    logic [31:0] sa;
    logic [7:0]  sl;
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[7];
    int   ar0, rq0;
    logic [31:0] sa;
    logic [7:0]  sl;

    vt[0] = '{32'h0000_1000, 40, 1'b0, 2'd0, 3, 32'h0000_1000, 15};
`ifdef RD_BURST_4K_SPLIT_EN
    vt[1] = '{32'h0000_0FC0, 16, 1'b1, 2'd1, 2, 32'h0000_0FC0, 7};
    vt[6] = '{32'h0000_4FF8, 3,  1'b1, 2'd1, 2, 32'h0000_4FF8, 0};
`else
    vt[1] = '{32'h0000_0FC0, 16, 1'b1, 2'd1, 1, 32'h0000_0FC0, 15};
    vt[6] = '{32'h0000_4FF8, 3,  1'b1, 2'd1, 1, 32'h0000_4FF8, 2};
`endif
    vt[2] = '{32'h0000_2000, 1,  1'b0, 2'd2, 1, 32'h0000_2000, 0};
    vt[3] = '{32'h0000_3000, 16, 1'b1, 2'd0, 1, 32'h0000_3000, 15};
    vt[4] = '{32'h0000_3008, 17, 1'b0, 2'd1, 2, 32'h0000_3008, 15};
    vt[5] = '{32'hFFFF_FF80, 32, 1'b1, 2'd2, 2, 32'hFFFF_FF80, 15};

    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_pu_id = 1'b0;
    cmd_d_type = '0; read_info_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ar_valid", ar_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_ar_addr_len", {ar_addr, ar_len}, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_cmd_ready", cmd_ready, 1);

    ar_mode = 0;
    foreach (vt[i]) begin
      ar0 = n_ar;
      send_cmd(vt[i].addr, vt[i].size, vt[i].pu, vt[i].dt, 1'b1);
      chk($sformatf("vec%0d_ar_addr0", i), ar_addr, vt[i].exp_addr0);
      chk($sformatf("vec%0d_ar_len0", i), ar_len, vt[i].exp_len0);
      wait_done();
      chk($sformatf("vec%0d_bursts", i), n_ar - ar0, vt[i].exp_bursts);
    end

    // Read-info FIFO full while in CALC
    read_info_full = 1'b1;
    ar_mode = 2;
    send_cmd(32'h0000_5000, 8, 1'b0, 2'd1, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("full_blocks", {busy, rd_req, ar_valid}, 3'b100);
    end
    @(posedge clk); #1;
    read_info_full = 1'b0;
    @(negedge clk);
    chk("full_clear_rd_req", rd_req, 1);
    chk("full_clear_no_ar_yet", ar_valid, 0);
    @(negedge clk);
    chk("full_clear_ar", ar_valid, 1);
    wait_done();

    // AR stalled for 5 cycles
    ar_mode = 1;
    rq0 = n_rq;
    send_cmd(32'h0000_6000, 4, 1'b1, 2'd2, 1'b1);
    sa = ar_addr; sl = ar_len;
    chk("stall_first_addr", sa, 32'h0000_6000);
    chk("stall_first_len", sl, 3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_stable", {ar_valid, ar_addr, ar_len}, {1'b1, 32'h0000_6000, 8'd3});
    end
    ar_mode = 2;
    wait_done();
    chk("stall_one_rd_req", n_rq - rq0, 1);

    // Zero-size command
    ar0 = n_ar; rq0 = n_rq;
    send_cmd(32'h0000_8000, 0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    chk("zero_busy", busy, 0);
    chk("zero_cmd_ready", cmd_ready, 1);
    repeat (3) @(negedge clk);
    chk("zero_no_traffic", {n_ar - ar0, n_rq - rq0}, 0);

    // Reset in ISSUE, between clock edges
    ar_mode = 1;
    send_cmd(32'h0000_7000, 40, 1'b1, 2'd1, 1'b1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("midrst_ar_valid", ar_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_outs", {rd_req, ar_addr, ar_len, cmd_ready}, 0);
    qa.delete(); qr.delete();
    n_ar = n_rq;
    @(posedge clk); #1;
    reset = 1'b0;
    ar_mode = 2;
    ar0 = n_ar; rq0 = n_rq;
    @(posedge clk); #1;
    chk("midrst_cmd_ready", cmd_ready, 1);
    repeat (10) @(negedge clk);
    chk("midrst_no_traffic", {n_ar - ar0, n_rq - rq0}, 0);
    chk("midrst_idle", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
